// File: rtl/tsens_uart_pkg.sv
// Shared types and constants for the temperature-sensor UART reader.
package tsens_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_LO,
    ST_WAIT_HI
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] CMD_READ_DEFAULT = 8'h52;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/tsens_uart_reader_if.sv
// Host-side signal bundle of the sensor UART reader; master is the reader itself.
interface tsens_uart_reader_if;
  logic        start;
  logic        rx;
  logic        tx;
  logic        busy;
  logic [15:0] result;
  logic        result_valid;
  logic        timeout_err;

  modport master (
    input  start, rx,
    output tx, busy, result, result_valid, timeout_err
  );

  modport slave (
    output start, rx,
    input  tx, busy, result, result_valid, timeout_err
  );
endinterface

// File: rtl/tsens_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, start-bit glitch re-check, mid-bit sampling.
// Held idle while i_enable is low so line activity outside a wait window is ignored.
module tsens_uart_rx_byte
  import tsens_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_rx,
  output logic       o_active,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic [7:0] o_byte
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  logic          r_sync1, r_sync2, r_rx_d;
  rx_state_t     r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_fall, w_mid_bit, w_half_bit, w_byte_valid, w_frame_err;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  assign w_fall     = r_rx_d & ~r_sync2;
  assign w_mid_bit  = (r_cnt == LAST_CNT);
  assign w_half_bit = (r_cnt == HALF_CNT);

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_next = RX_START;
      RX_START: if (w_half_bit) w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_mid_bit && (r_bit == 3'd7)) w_state_next = RX_STOP;
      RX_STOP: begin
        if (w_mid_bit) begin
          w_state_next = RX_IDLE;
          w_byte_valid = r_sync2;
          w_frame_err  = ~r_sync2;
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
    if (!i_enable) begin
      w_state_next = RX_IDLE;
      w_byte_valid = 1'b0;
      w_frame_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= RX_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      // Count restarts on every phase change and on every sampled bit.
      if ((w_state_next != r_state) || w_mid_bit || (r_state == RX_IDLE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if ((r_state == RX_DATA) && w_mid_bit) begin
        r_shift <= {r_sync2, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end else if (r_state != RX_DATA) begin
        r_bit <= '0;
      end
    end
  end

  assign o_active     = (r_state != RX_IDLE);
  assign o_byte_valid = w_byte_valid;
  assign o_frame_err  = w_frame_err;
  assign o_byte       = r_shift;

endmodule

// File: rtl/tsens_uart_reader.sv
// Initiator end of the temperature-sensor UART link: sends CMD_READ, collects {hi,lo}.
// Optional TSREAD_RETRY_EN: one silent command retry per transaction before reporting an error.
module tsens_uart_reader
  import tsens_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 10000,
  parameter int unsigned BAUD           = 1000,
  parameter logic [7:0]  CMD_READ       = CMD_READ_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 400
) (
  input  logic                clk,
  input  logic                reset,
  tsens_uart_reader_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state, w_state_next;
  logic          r_tx;
  logic [8:0]    r_frame;
  logic [CW-1:0] r_clk_cnt;
  logic [3:0]    r_bit_idx;
  logic [TW-1:0] r_tmo_cnt;
  logic [7:0]    r_lo;
  logic [15:0]   r_result;
  logic          r_result_valid, r_timeout_err;

  logic       w_waiting, w_bit_end, w_tmo_hit;
  logic       w_load_cmd, w_err, w_report, w_capture_lo, w_capture_hi;
  logic       w_rx_active, w_byte_valid, w_frame_err;
  logic [7:0] w_byte;

`ifdef TSREAD_RETRY_EN
  logic r_retried;
`endif

  assign w_waiting = (r_state == ST_WAIT_LO) || (r_state == ST_WAIT_HI);
  assign w_bit_end = (r_clk_cnt == LAST_CNT);
  assign w_tmo_hit = w_waiting && !w_rx_active && (r_tmo_cnt == TMO_LAST);

  tsens_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (w_waiting),
    .i_rx         (bus.rx),
    .o_active     (w_rx_active),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err),
    .o_byte       (w_byte)
  );

  always_comb begin
    w_state_next = r_state;
    w_load_cmd   = 1'b0;
    w_err        = 1'b0;
    w_report     = 1'b0;
    w_capture_lo = 1'b0;
    w_capture_hi = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_SEND_CMD;
          w_load_cmd   = 1'b1;
        end
      end
      ST_SEND_CMD: if (w_bit_end && (r_bit_idx == 4'd9)) w_state_next = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (w_byte_valid) begin
          w_state_next = ST_WAIT_HI;
          w_capture_lo = 1'b1;
        end else if (w_frame_err || w_tmo_hit) begin
          w_err = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (w_byte_valid) begin
          w_state_next = ST_IDLE;
          w_capture_hi = 1'b1;
        end else if (w_frame_err || w_tmo_hit) begin
          w_err = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_err) begin
`ifdef TSREAD_RETRY_EN
      if (!r_retried) begin
        w_state_next = ST_SEND_CMD;
        w_load_cmd   = 1'b1;
      end else begin
        w_state_next = ST_IDLE;
        w_report     = 1'b1;
      end
`else
      w_state_next = ST_IDLE;
      w_report     = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx           <= 1'b1;
      r_frame        <= '1;
      r_clk_cnt      <= '0;
      r_bit_idx      <= '0;
      r_tmo_cnt      <= '0;
      r_lo           <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_result_valid <= w_capture_hi;
      r_timeout_err  <= w_report;

      // Start bit goes out immediately; r_frame holds data bits then the stop bit.
      if (w_load_cmd) begin
        r_tx      <= 1'b0;
        r_frame   <= {1'b1, CMD_READ};
        r_clk_cnt <= '0;
        r_bit_idx <= '0;
      end else if (r_state == ST_SEND_CMD) begin
        if (w_bit_end) begin
          r_clk_cnt <= '0;
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= r_frame[0];
          r_frame   <= {1'b1, r_frame[8:1]};
        end else begin
          r_clk_cnt <= r_clk_cnt + CW'(1);
        end
      end

      if (w_state_next != r_state)
        r_tmo_cnt <= '0;
      else if (w_waiting && !w_rx_active)
        r_tmo_cnt <= r_tmo_cnt + TW'(1);

      if (w_capture_lo)      r_lo <= w_byte;
      else if (w_load_cmd)   r_lo <= '0;
      if (w_capture_hi)      r_result <= {w_byte, r_lo};
    end
  end

`ifdef TSREAD_RETRY_EN
  always_ff @(posedge clk) begin
    if (!reset)                     r_retried <= 1'b0;
    else if (r_state == ST_IDLE)    r_retried <= 1'b0;
    else if (w_err)                 r_retried <= 1'b1;
  end
`endif

  assign bus.tx           = r_tx;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.timeout_err  = r_timeout_err;

endmodule
